// File: rtl/serial_magnitude_comparator_pkg.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator_pkg
//   Shared definitions for the bit-serial magnitude comparator.
//   - state_t : FSM state encodings (IDLE / SHIFT / DONE). The fourth 2-bit
//               code is unused and is treated as illegal by the FSM.
// -----------------------------------------------------------------------------
package serial_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_magnitude_comparator_pkg

// File: rtl/serial_magnitude_comparator_if.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator_if
//   Request/result bundle of the serial magnitude comparator.
//   Signals:
//     start      request a comparison (sampled only while the comparator idles)
//     a_in, b_in WIDTH-bit operands, captured on the accepted start edge
//     busy       high while bits are being compared
//     done       one-cycle completion pulse
//     g, e, l    registered result: A > B, A == B, A < B
//   Modports:
//     master : requester side (drives start/operands, observes status/result)
//     slave  : comparator side
// -----------------------------------------------------------------------------
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             g;
  logic             e;
  logic             l;

  modport master (
    output start, a_in, b_in,
    input  busy, done, g, e, l
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, g, e, l
  );

endinterface : serial_magnitude_comparator_if

// File: rtl/serial_magnitude_comparator_one_bit.sv
// -----------------------------------------------------------------------------
// one_bit_comparator
//   Purely combinational single-bit magnitude comparator.
//   Ports:
//     g : output, a > b
//     e : output, a == b
//     l : output, a < b
//     a : input, bit of operand A
//     b : input, bit of operand B
//   Exactly one of g/e/l is high for any input pair.
// -----------------------------------------------------------------------------
module one_bit_comparator (
  output logic g,
  output logic e,
  output logic l,
  input  logic a,
  input  logic b
);

  assign g = a & ~b;
  assign e = ~(a ^ b);
  assign l = ~a & b;

endmodule : one_bit_comparator

// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//   Bit-serial WIDTH-bit magnitude comparator. On an accepted start the two
//   operands are captured into shift registers and presented MSB first, one
//   bit pair per cycle, to a one_bit_comparator. The first differing bit ends
//   the comparison early; equal operands finish after WIDTH bits. Completion
//   is signalled with a one-cycle done pulse and the registered g/e/l result
//   holds until the next accepted start.
//   Parameters:
//     WIDTH : operand width in bits (>= 2)
//     CNT_W : width of the remaining-bit counter
//   Ports:
//     clk   : input, rising-edge clock
//     rst_n : input, synchronous active-low reset
//     cmp   : slave side of serial_magnitude_comparator_if
//             (start, a_in, b_in in; busy, done, g, e, l out)
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  cmp
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_g;
  logic             r_e;
  logic             r_l;

  logic             w_bit_g;
  logic             w_bit_e;
  logic             w_bit_l;

  // The MSB of each shift register is the bit currently under comparison.
  one_bit_comparator u_bit_cmp (
    .g (w_bit_g),
    .e (w_bit_e),
    .l (w_bit_l),
    .a (r_a_sh[WIDTH-1]),
    .b (r_b_sh[WIDTH-1])
  );

  // NOTE: every register in this block uses non-blocking assignments so that
  // all reads within one edge see the pre-edge values, regardless of the
  // order of statements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g     <= 1'b0;
      r_e     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (cmp.start) begin
            r_a_sh  <= cmp.a_in;
            r_b_sh  <= cmp.b_in;
            r_cnt   <= CNT_LAST;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_bit_g || w_bit_l || (r_cnt == '0)) begin
            // Decision reached: either a differing bit, or the LSB matched
            // after all higher bits matched, which means equality.
            r_g     <= w_bit_g;
            r_l     <= w_bit_l;
            r_e     <= w_bit_e;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_a_sh <= {r_a_sh[WIDTH-2:0], 1'b0};
            r_b_sh <= {r_b_sh[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        // NOTE: the spare encoding recovers to IDLE with status flags
        // cleared; the result registers are left alone so a held result is
        // not disturbed.
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmp.busy = r_busy;
  assign cmp.done = r_done;
  assign cmp.g    = r_g;
  assign cmp.e    = r_e;
  assign cmp.l    = r_l;

endmodule : serial_magnitude_comparator

// File: tb/tb_serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_magnitude_comparator
//   Directed self-checking bench for serial_magnitude_comparator (WIDTH = 8).
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_magnitude_comparator;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  int n_total;
  int n_bad;

  serial_magnitude_comparator_if #(.WIDTH(WIDTH)) cmp_if ();

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cmp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] gel_now();
    return {cmp_if.g, cmp_if.e, cmp_if.l};
  endfunction

  // Reference: latency = position of first differing bit counted from the MSB
  // (1-based); equal operands take WIDTH cycles.
  function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int p = WIDTH - 1; p >= 0; p--) begin
      if (a[p] != b[p]) return WIDTH - p;
    end
    return WIDTH;
  endfunction

  function automatic logic [2:0] ref_gel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // One complete comparison: start pulse, operands scrambled after edge 0,
  // bounded wait for done, result and hold checks.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int exp_lat,
                         input logic [2:0] exp_gel);
    int lat;
    @(negedge clk);
    cmp_if.start = 1'b1;
    cmp_if.a_in  = a;
    cmp_if.b_in  = b;
    @(posedge clk); #1;                  // edge 0
    check({tag, "_busy_after_start"}, 32'(cmp_if.busy), 32'd1);
    check({tag, "_gel_cleared"}, 32'(gel_now()), 32'd0);
    @(negedge clk);
    cmp_if.start = 1'b0;
    cmp_if.a_in  = ~a;                   // reverses the relation if it leaked in
    cmp_if.b_in  = ~b;
    lat = 0;
    for (int n = 1; n <= WIDTH + 2; n++) begin
      @(posedge clk); #1;
      if (cmp_if.done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_gel"}, 32'(gel_now()), 32'(exp_gel));
    check({tag, "_busy_in_done"}, 32'(cmp_if.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 32'(cmp_if.done), 32'd0);
    check({tag, "_gel_hold"}, 32'(gel_now()), 32'(exp_gel));
  endtask

  initial begin
    int seen;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    n_total = 0;
    n_bad   = 0;

    // Reset with start asserted and operands that would decide on the MSB.
    rst_n        = 1'b0;
    cmp_if.start = 1'b1;
    cmp_if.a_in  = 8'hFF;
    cmp_if.b_in  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(cmp_if.busy), 32'd0);
    check("rst_done", 32'(cmp_if.done), 32'd0);
    check("rst_gel", 32'(gel_now()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_accept", 32'(cmp_if.busy), 32'd1);
    @(posedge clk); #1;
    check("post_rst_done", 32'(cmp_if.done), 32'd1);
    check("post_rst_gel", 32'(gel_now()), 32'b100);
    @(negedge clk);
    cmp_if.start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(cmp_if.done), 32'd0);

    // Directed vectors with hand-computed results.
    run_cmp("msb",   8'hA5, 8'h25, 1, 3'b100);
    run_cmp("mid",   8'h12, 8'h1A, 5, 3'b001);
    run_cmp("lsb",   8'h10, 8'h11, 8, 3'b001);
    run_cmp("equal", 8'h3C, 8'h3C, 8, 3'b010);

    // Back-to-back: start held high, operands changed during SHIFT.
    @(negedge clk);
    cmp_if.start = 1'b1;
    cmp_if.a_in  = 8'h40;
    cmp_if.b_in  = 8'h41;
    @(posedge clk); #1;                  // edge 0, first comparison
    @(negedge clk);
    cmp_if.a_in  = 8'hFF;
    cmp_if.b_in  = 8'h00;
    repeat (7) @(posedge clk);
    #1;
    check("b2b_not_done_yet", 32'(cmp_if.done), 32'd0);
    @(posedge clk); #1;                  // edge 8
    check("b2b_first_done", 32'(cmp_if.done), 32'd1);
    check("b2b_first_gel", 32'(gel_now()), 32'b001);
    @(posedge clk); #1;                  // DONE -> IDLE, start ignored here
    check("b2b_idle_busy", 32'(cmp_if.busy), 32'd0);
    check("b2b_idle_gel_hold", 32'(gel_now()), 32'b001);
    @(posedge clk); #1;                  // IDLE accepts held start
    check("b2b_second_busy", 32'(cmp_if.busy), 32'd1);
    check("b2b_second_cleared", 32'(gel_now()), 32'd0);
    @(negedge clk);
    cmp_if.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_second_done", 32'(cmp_if.done), 32'd1);
    check("b2b_second_gel", 32'(gel_now()), 32'b100);
    @(posedge clk); #1;

    // Reset in the middle of a comparison.
    @(negedge clk);
    cmp_if.start = 1'b1;
    cmp_if.a_in  = 8'h01;
    cmp_if.b_in  = 8'h00;
    @(posedge clk);                      // edge 0
    @(negedge clk);
    cmp_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(cmp_if.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(cmp_if.busy), 32'd0);
    check("abort_done", 32'(cmp_if.done), 32'd0);
    check("abort_gel", 32'(gel_now()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (cmp_if.done || cmp_if.busy) seen++;
    end
    check("abort_stays_idle", 32'(seen), 32'd0);

    // Sweep: random, equal and single-bit-difference pairs against the model.
    for (int i = 0; i < 1500; i++) begin
      a = WIDTH'($urandom);
      case (i % 3)
        0:       b = WIDTH'($urandom);
        1:       b = a;
        default: b = a ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
      endcase
      run_cmp("sweep", a, b, ref_lat(a, b), ref_gel(a, b));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_serial_magnitude_comparator
